// File: rtl/jpeg_dec_reorder_buf_if.sv
// Coefficient-in / raster-out bus of the JPEG decoder reorder buffer.
// master = entropy-decode + IDCT side driving the buffer, slave = the buffer itself.
interface jpeg_dec_reorder_buf_if #(
  parameter int DW = 12
) ();
  logic          PI_EN;
  logic [DW-1:0] PI;
  logic          PI_DC;
  logic          PI_LST;
  logic [3:0]    PI_ZR;
  logic          REORD_AFULL;
  logic          RO_STALL;
  logic          RO_EN;
  logic [DW-1:0] RO;
  logic          RO_SOB;
  logic          RO_EOB;
  logic          ERR;

  modport master (
    output PI_EN, PI, PI_DC, PI_LST, PI_ZR, RO_STALL,
    input  REORD_AFULL, RO_EN, RO, RO_SOB, RO_EOB, ERR
  );

  modport slave (
    input  PI_EN, PI, PI_DC, PI_LST, PI_ZR, RO_STALL,
    output REORD_AFULL, RO_EN, RO, RO_SOB, RO_EOB, ERR
  );
endinterface

// File: rtl/jpeg_dec_reorder_buf.sv
// Two-bank zigzag-to-raster coefficient reorder buffer between entropy decode and IDCT.
// Define JPEG_DEC_REORD_ERR_EN to enable the sticky protocol-error flag ERR.
module jpeg_dec_reorder_buf #(
  parameter int DW = 12
) (
  input  logic                   HCLK,
  input  logic                   HRESETn,
  input  logic                   INIT,
  jpeg_dec_reorder_buf_if.slave  bus
);

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bank_state_t;

  // Zigzag position -> natural (raster) position
  localparam logic [5:0] ZZ [64] = '{
    6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
    6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
    6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
    6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
    6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
    6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
    6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
    6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
  };

  bank_state_t   r_state [2];
  bank_state_t   w_state_next [2];
  logic [63:0]   r_mask [2];
  logic [63:0]   w_mask_next [2];
  logic          r_wb, w_wb_next;
  logic          r_rb, w_rb_next;
  logic [6:0]    r_k, w_k_next;
  logic [5:0]    r_n, w_n_next;

  logic [DW-1:0] r_mem [128];
  logic [DW-1:0] r_ro_raw;
  logic          r_ro_en;
  logic          r_sob;
  logic          r_eob;
  logic          r_ro_mask;

  logic [6:0]    w_tgt;
  logic [5:0]    w_zz_addr;
  logic          w_fill_ok;
  logic          w_wr;
  logic          w_restart;
  logic          w_rd;

  assign w_tgt     = bus.PI_DC ? 7'd0 : (r_k + {3'b000, bus.PI_ZR});
  assign w_zz_addr = ZZ[w_tgt[5:0]];
  assign w_fill_ok = bus.PI_EN &&
                     (r_state[r_wb] == B_EMPTY || r_state[r_wb] == B_FILLING);
  assign w_wr      = w_fill_ok && (w_tgt <= 7'd63);
  // A DC beat in mid-block restarts it, so the old mask must go too
  assign w_restart = w_fill_ok &&
                     (r_state[r_wb] == B_EMPTY || (bus.PI_DC && r_k != 7'd0));
  assign w_rd      = (r_state[r_rb] == B_DRAINING) && !bus.RO_STALL;

  always_comb begin
    w_state_next[0] = r_state[0];
    w_state_next[1] = r_state[1];
    w_mask_next[0]  = r_mask[0];
    w_mask_next[1]  = r_mask[1];
    w_wb_next       = r_wb;
    w_rb_next       = r_rb;
    w_k_next        = r_k;
    w_n_next        = r_n;

    if (w_fill_ok) begin
      if (w_restart) begin
        w_mask_next[r_wb] = '0;
      end
      if (w_wr) begin
        w_mask_next[r_wb][w_zz_addr] = 1'b1;
        w_k_next = w_tgt + 7'd1;
      end else begin
        w_k_next = 7'd64;
      end
      if (bus.PI_LST) begin
        w_state_next[r_wb] = B_FULL;
        w_k_next           = 7'd0;
        w_wb_next          = ~r_wb;
      end else begin
        w_state_next[r_wb] = B_FILLING;
      end
    end

    // Fill only touches EMPTY/FILLING banks and drain only FULL/DRAINING ones,
    // so both updates can land on the same edge without colliding.
    if (r_state[r_rb] == B_FULL) begin
      w_state_next[r_rb] = B_DRAINING;
      w_n_next           = 6'd0;
    end else if (w_rd) begin
      w_n_next = r_n + 6'd1;
      if (r_n == 6'd63) begin
        w_state_next[r_rb] = B_EMPTY;
        w_rb_next          = ~r_rb;
      end
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_state[0] <= B_EMPTY;
      r_state[1] <= B_EMPTY;
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_k        <= 7'd0;
      r_n        <= 6'd0;
      r_ro_en    <= 1'b0;
      r_sob      <= 1'b0;
      r_eob      <= 1'b0;
      r_ro_mask  <= 1'b0;
    end else if (INIT) begin
      r_state[0] <= B_EMPTY;
      r_state[1] <= B_EMPTY;
      r_wb       <= 1'b0;
      r_rb       <= 1'b0;
      r_k        <= 7'd0;
      r_n        <= 6'd0;
      r_ro_en    <= 1'b0;
      r_sob      <= 1'b0;
      r_eob      <= 1'b0;
      r_ro_mask  <= 1'b0;
    end else begin
      r_state[0] <= w_state_next[0];
      r_state[1] <= w_state_next[1];
      r_wb       <= w_wb_next;
      r_rb       <= w_rb_next;
      r_k        <= w_k_next;
      r_n        <= w_n_next;
      r_ro_en    <= w_rd;
      if (w_rd) begin
        r_sob     <= (r_n == 6'd0);
        r_eob     <= (r_n == 6'd63);
        r_ro_mask <= r_mask[r_rb][r_n];
      end
    end
  end

  // Masks need no reset: every block start clears its bank's mask
  always_ff @(posedge HCLK) begin
    r_mask[0] <= w_mask_next[0];
    r_mask[1] <= w_mask_next[1];
  end

  always_ff @(posedge HCLK) begin
    if (w_wr) begin
      r_mem[{r_wb, w_zz_addr}] <= bus.PI;
    end
    if (w_rd) begin
      r_ro_raw <= r_mem[{r_rb, r_n}];
    end
  end

  assign bus.REORD_AFULL = (r_state[0] != B_EMPTY) && (r_state[1] != B_EMPTY);
  assign bus.RO_EN       = r_ro_en;
  assign bus.RO          = r_ro_mask ? r_ro_raw : '0;
  assign bus.RO_SOB      = r_sob & r_ro_en;
  assign bus.RO_EOB      = r_eob & r_ro_en;

`ifdef JPEG_DEC_REORD_ERR_EN
  logic r_err;
  logic w_err_set;

  assign w_err_set = (bus.PI_EN && !w_fill_ok) ||
                     (w_fill_ok && !w_wr) ||
                     (w_fill_ok && bus.PI_DC && r_k != 7'd0);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      r_err <= 1'b0;
    end else if (INIT) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end
  end

  assign bus.ERR = r_err;
`else
  assign bus.ERR = 1'b0;
`endif

endmodule

// File: tb/tb_jpeg_dec_reorder_buf.sv
// Scoreboard bench for jpeg_dec_reorder_buf: directed blocks in, raster beats checked by a monitor.
module tb_jpeg_dec_reorder_buf;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic init = 1'b0;

  always #5 clk = ~clk;

  jpeg_dec_reorder_buf_if #(.DW(12)) bus ();

  jpeg_dec_reorder_buf #(.DW(12)) dut (
    .HCLK    (clk),
    .HRESETn (rst_n),
    .INIT    (init),
    .bus     (bus)
  );

  typedef struct {
    logic [11:0] v;
    logic        sob;
    logic        eob;
  } exp_t;

  exp_t        sb_q [$];
  logic [11:0] exp_blk [64];
  int          total = 0;
  int          bad = 0;
  int          pop_cnt = 0;
  int          base = 0;
  logic        chk_hold = 1'b0;
  logic        have_last = 1'b0;
  logic [11:0] last_ro = '0;
  logic        err_exp;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clr_blk();
    for (int i = 0; i < 64; i++) exp_blk[i] = 12'd0;
  endtask

  task automatic push_blk();
    for (int i = 0; i < 64; i++)
      sb_q.push_back('{v: exp_blk[i], sob: (i == 0), eob: (i == 63)});
  endtask

  task automatic beat(input logic [11:0] v, input logic dc, input logic [3:0] zr, input logic lst);
    @(negedge clk);
    bus.PI_EN  = 1'b1;
    bus.PI     = v;
    bus.PI_DC  = dc;
    bus.PI_ZR  = zr;
    bus.PI_LST = lst;
    @(posedge clk);
    #1;
    bus.PI_EN  = 1'b0;
    bus.PI_DC  = 1'b0;
    bus.PI_LST = 1'b0;
    bus.PI_ZR  = 4'd0;
  endtask

  task automatic wait_drain(input int limit, input string name);
    int c;
    c = 0;
    while (sb_q.size() != 0 && c < limit) begin
      @(negedge clk);
      c++;
    end
    check(name, sb_q.size(), 0);
    @(negedge clk);
  endtask

  // Monitor: every RO_EN beat pops one expected raster coefficient
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.RO_EN === 1'b1) begin
        if (sb_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_beat: got RO=%0h with empty scoreboard", bus.RO);
        end else begin
          e = sb_q.pop_front();
          check("ro_data", bus.RO, e.v);
          check("ro_sob", bus.RO_SOB, e.sob);
          check("ro_eob", bus.RO_EOB, e.eob);
          if (e.eob) $display("block drained: beats so far=%0d", pop_cnt + 1);
          pop_cnt++;
          last_ro   = bus.RO;
          have_last = 1'b1;
        end
      end else if (chk_hold && have_last) begin
        check("ro_hold", bus.RO, last_ro);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    bus.PI_EN    = 1'b0;
    bus.PI       = '0;
    bus.PI_DC    = 1'b0;
    bus.PI_LST   = 1'b0;
    bus.PI_ZR    = 4'd0;
    bus.RO_STALL = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ro_en", bus.RO_EN, 0);
    check("rst_ro", bus.RO, 0);
    check("rst_afull", bus.REORD_AFULL, 0);
    check("rst_err", bus.ERR, 0);
    check("rst_sob", bus.RO_SOB, 0);
    check("rst_eob", bus.RO_EOB, 0);
    rst_n = 1'b1;

    // DC/AC/EOB block plus first-output latency
    clr_blk(); exp_blk[0] = 12'd100; exp_blk[1] = 12'hFFB; push_blk();
    base = pop_cnt;
    beat(12'd100, 1'b1, 4'd0, 1'b0);
    beat(12'hFFB, 1'b0, 4'd0, 1'b0);
    beat(12'd0,   1'b0, 4'd0, 1'b1);
    @(negedge clk); check("lat_t0", bus.RO_EN, 0);
    @(negedge clk); check("lat_t1", bus.RO_EN, 0);
    @(negedge clk); check("lat_t2", bus.RO_EN, 1);
    wait_drain(200, "t1_drain");
    check("t1_count", pop_cnt - base, 64);

    // Zero run lands on zigzag 3 -> raster 16
    clr_blk(); exp_blk[0] = 12'd7; exp_blk[16] = 12'd3; push_blk();
    base = pop_cnt;
    beat(12'd7, 1'b1, 4'd0, 1'b0);
    beat(12'd3, 1'b0, 4'd2, 1'b1);
    wait_drain(200, "t2_drain");
    check("t2_count", pop_cnt - base, 64);

    // Three back-to-back blocks, upstream honouring REORD_AFULL
    base = pop_cnt;
    clr_blk(); exp_blk[0] = 12'd11; exp_blk[1] = 12'd22; exp_blk[16] = 12'd33; exp_blk[9] = 12'd44; push_blk();
    clr_blk(); exp_blk[0] = 12'd55; exp_blk[8] = 12'd66; push_blk();
    beat(12'd11, 1'b1, 4'd0, 1'b0);
    beat(12'd22, 1'b0, 4'd0, 1'b0);
    beat(12'd33, 1'b0, 4'd1, 1'b0);
    beat(12'd44, 1'b0, 4'd0, 1'b1);
    check("t3_afull_one_bank", bus.REORD_AFULL, 0);
    beat(12'd55, 1'b1, 4'd0, 1'b0);
    check("t3_afull_second_start", bus.REORD_AFULL, 1);
    beat(12'd66, 1'b0, 4'd1, 1'b1);
    check("t3_afull_both_full", bus.REORD_AFULL, 1);
    for (int c = 0; c < 300 && bus.REORD_AFULL === 1'b1; c++) @(negedge clk);
    check("t3_afull_release", bus.REORD_AFULL, 0);
    clr_blk(); exp_blk[0] = 12'd77; exp_blk[12] = 12'd88; push_blk();
    beat(12'd77, 1'b1, 4'd0, 1'b0);
    beat(12'd88, 1'b0, 4'd15, 1'b1);
    wait_drain(400, "t3_drain");
    check("t3_count", pop_cnt - base, 192);

    // RO_STALL toggling every cycle during drain
    clr_blk(); exp_blk[0] = 12'd5; exp_blk[1] = 12'd6; exp_blk[8] = 12'd9; push_blk();
    base = pop_cnt;
    beat(12'd5, 1'b1, 4'd0, 1'b0);
    beat(12'd6, 1'b0, 4'd0, 1'b0);
    beat(12'd9, 1'b0, 4'd0, 1'b1);
    chk_hold = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(posedge clk);
      #1;
      bus.RO_STALL = ~bus.RO_STALL;
    end
    bus.RO_STALL = 1'b0;
    wait_drain(200, "t4_drain");
    chk_hold = 1'b0;
    check("t4_count", pop_cnt - base, 64);

    // Zero run overflowing position 63 drops the beat
    check("t5_err_pre", bus.ERR, 0);
    clr_blk();
    exp_blk[0] = 12'd1; exp_blk[12] = 12'd2; exp_blk[35] = 12'd3; exp_blk[58] = 12'd4; exp_blk[54] = 12'd5;
    push_blk();
    base = pop_cnt;
    beat(12'd1,  1'b1, 4'd0,  1'b0);
    beat(12'd2,  1'b0, 4'd15, 1'b0);
    beat(12'd3,  1'b0, 4'd15, 1'b0);
    beat(12'd4,  1'b0, 4'd15, 1'b0);
    beat(12'd5,  1'b0, 4'd10, 1'b0);
    beat(12'd99, 1'b0, 4'd5,  1'b1);
`ifdef JPEG_DEC_REORD_ERR_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    @(negedge clk);
    check("t5_err", bus.ERR, err_exp);
    wait_drain(200, "t5_drain");
    check("t5_count", pop_cnt - base, 64);

    // INIT at beat 30 of block 2 while block 1 drains
    clr_blk(); exp_blk[0] = 12'd10; exp_blk[1] = 12'd20; push_blk();
    beat(12'd10, 1'b1, 4'd0, 1'b0);
    beat(12'd20, 1'b0, 4'd0, 1'b1);
    beat(12'd1, 1'b1, 4'd0, 1'b0);
    for (int i = 1; i < 29; i++) beat(12'(i + 1), 1'b0, 4'd0, 1'b0);
    check("t6_afull_pre", bus.REORD_AFULL, 1);
    check("t6_draining_pre", bus.RO_EN, 1);
    @(negedge clk);
    init = 1'b1;
    @(posedge clk);
    #1;
    init = 1'b0;
    sb_q.delete();
    have_last = 1'b0;
    check("t6_ro_en", bus.RO_EN, 0);
    check("t6_afull", bus.REORD_AFULL, 0);
    check("t6_ro", bus.RO, 0);
    check("t6_err", bus.ERR, 0);
    clr_blk(); exp_blk[0] = 12'd123; exp_blk[9] = 12'd45; push_blk();
    base = pop_cnt;
    beat(12'd123, 1'b1, 4'd0, 1'b0);
    beat(12'd45,  1'b0, 4'd3, 1'b1);
    wait_drain(200, "t6_drain");
    check("t6_count", pop_cnt - base, 64);

    repeat (20) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
